// File: rtl/ddr_pattern_tester.sv
// Self-running MIG UI memory test: writes a seed-derived pattern over NUM_WORDS
// consecutive UI words, reads it back, and reports pass/fail with error stats.
module ddr_pattern_tester #(
   parameter int ADDR_WIDTH     = 27,
   parameter int APP_DATA_WIDTH = 64,
   parameter int APP_MASK_WIDTH = 8,
   parameter int ADDR_STEP      = 8,
   parameter int NUM_WORDS      = 256,
   parameter int TIMEOUT        = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [31:0]               seed,
   input  logic                      init_calib_complete,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_rdy,
   input  logic                      app_wdf_rdy,
   input  logic                      app_rd_data_valid,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [15:0]               err_count,
   output logic [ADDR_WIDTH-1:0]     first_err_addr
);
   typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DONE} state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [16:0] NW = 17'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

   state_t                  state;
   logic [1:0]              mode_r;
   logic [ADDR_WIDTH-1:0]   base_r, rd_addr;
   logic [31:0]             seed_r;
   logic [16:0]             cc, dc, rc, cc_n, dc_n;
   logic [WD_W-1:0]         wd;
   logic                    cmd_hs, dat_hs, rsp;
   logic [APP_DATA_WIDTH-1:0] rd_exp;

   // Even 32-bit lanes carry p, odd lanes carry ~p.
   function automatic logic [APP_DATA_WIDTH-1:0] pattern(input logic [31:0] p);
      logic [APP_DATA_WIDTH-1:0] w;
      w = '0;
      for (int k = 0; k < APP_DATA_WIDTH / 32; k++)
         w[k*32 +: 32] = (k % 2 == 1) ? ~p : p;
      return w;
   endfunction

   assign app_wdf_mask = '0;
   assign app_wdf_end  = app_wdf_wren;
   assign cmd_hs = app_en & app_rdy;
   assign dat_hs = app_wdf_wren & app_wdf_rdy;
   assign rsp    = app_rd_data_valid && (state == READ);
   assign cc_n   = cc + {16'd0, cmd_hs};
   assign dc_n   = dc + {16'd0, dat_hs};
   assign rd_exp = pattern(seed_r + 32'(rc));

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         mode_r         <= 2'b00;
         base_r         <= '0;
         seed_r         <= '0;
         rd_addr        <= '0;
         cc             <= '0;
         dc             <= '0;
         rc             <= '0;
         wd             <= '0;
         app_addr       <= '0;
         app_cmd        <= 3'b001;
         app_en         <= 1'b0;
         app_wdf_data   <= '0;
         app_wdf_wren   <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               mode_r         <= (mode == 2'b11) ? 2'b00 : mode;
               base_r         <= base_addr;
               seed_r         <= seed;
               busy           <= 1'b1;
               done           <= 1'b0;
               pass           <= 1'b0;
               timeout        <= 1'b0;
               err_count      <= '0;
               first_err_addr <= '0;
               wd             <= '0;
               state          <= WAIT_CAL;
            end
            WAIT_CAL: if (init_calib_complete) begin
               cc       <= '0;
               dc       <= '0;
               rc       <= '0;
               wd       <= '0;
               app_addr <= base_r;
               rd_addr  <= base_r;
               app_en   <= 1'b1;
               if (mode_r == 2'b10) begin
                  app_cmd <= 3'b001;
                  state   <= READ;
               end else begin
                  app_cmd      <= 3'b000;
                  app_wdf_wren <= 1'b1;
                  app_wdf_data <= pattern(seed_r);
                  state        <= WRITE;
               end
            end
            WRITE: begin
               cc <= cc_n;
               dc <= dc_n;
               if (cmd_hs) app_addr <= app_addr + STEP;
               if (dat_hs) app_wdf_data <= pattern(seed_r + 32'(dc_n));
               app_wdf_wren <= (dc_n < NW);
               // Commands are held back so data never trails by more than two words.
               app_en <= (cc_n < NW) && (cc_n <= dc_n + 17'd1);
               if (cc_n == NW && dc_n == NW) begin
                  cc       <= '0;
                  app_addr <= base_r;
                  if (mode_r == 2'b01) begin
                     app_en <= 1'b0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     pass   <= (err_count == 16'd0);
                     state  <= DONE;
                  end else begin
                     app_cmd <= 3'b001;
                     app_en  <= 1'b1;
                     state   <= READ;
                  end
               end
            end
            READ: begin
               cc <= cc_n;
               if (cmd_hs) app_addr <= app_addr + STEP;
               app_en <= (cc_n < NW);
               if (rsp) begin
                  rc      <= rc + 17'd1;
                  rd_addr <= rd_addr + STEP;
                  if (app_rd_data != rd_exp) begin
                     if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                     if (err_count == 16'd0) first_err_addr <= rd_addr;
                  end
               end
               if (rc == NW) begin
                  app_en <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= (err_count == 16'd0);
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase

         // Watchdog overrides any transition taken above in the same cycle.
         if (state == WAIT_CAL || state == WRITE || state == READ) begin
            if (cmd_hs || dat_hs || rsp) begin
               wd <= '0;
            end else if (wd == WD_W'(TIMEOUT - 1)) begin
               timeout      <= 1'b1;
               app_en       <= 1'b0;
               app_wdf_wren <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b1;
               pass         <= 1'b0;
               state        <= DONE;
            end else begin
               wd <= wd + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ddr_pattern_tester.sv
// Bench for ddr_pattern_tester: MIG UI model with memory, backpressure, error
// injection and stale-read tagging; scenario table plus hand-written corner cases.
module tb_ddr_pattern_tester;
   logic        clk, rst, start, calib;
   logic [1:0]  mode;
   logic [26:0] base_addr, app_addr, first_err_addr;
   logic [31:0] seed;
   logic [2:0]  app_cmd;
   logic        app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy, app_rd_data_valid;
   logic [63:0] app_wdf_data, app_rd_data;
   logic [7:0]  app_wdf_mask;
   logic        busy, done, pass, timeout;
   logic [15:0] err_count;

   ddr_pattern_tester #(.ADDR_WIDTH(27), .APP_DATA_WIDTH(64), .APP_MASK_WIDTH(8),
                        .ADDR_STEP(8), .NUM_WORDS(16), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .seed(seed),
      .init_calib_complete(calib), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data), .busy(busy),
      .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
      .first_err_addr(first_err_addr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model controls, written only by the main process.
   bit bp, hold;
   int flip_at, epoch;
   // Model state, written only by the model process.
   logic [63:0] mem [logic [26:0]];
   logic [26:0] waq[$], addr_log[$];
   logic [63:0] wdq[$], rq[$], beat_log[$];
   int          rq_ep[$];
   int          n_wr, n_rd, n_beat, n_rsp, stab_bad;

   initial begin
      n_wr = 0; n_rd = 0; n_beat = 0; n_rsp = 0; stab_bad = 0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
   end

   always begin : mig_model
      logic        p_en, p_rdy, p_wren, p_wrdy, p_rst;
      logic [26:0] p_addr;
      logic [2:0]  p_cmd;
      logic [63:0] p_wdata, d;
      int          ep;
      p_en = 0; p_rdy = 0; p_wren = 0; p_wrdy = 0; p_rst = 1;
      p_addr = '0; p_cmd = '0; p_wdata = '0;
      forever begin
         @(posedge clk);
         if (!p_rst && p_en && !p_rdy && !(app_en && app_addr == p_addr && app_cmd == p_cmd))
            stab_bad++;
         if (!p_rst && p_wren && !p_wrdy && !(app_wdf_wren && app_wdf_data == p_wdata))
            stab_bad++;
         if (app_en && app_rdy) begin
            addr_log.push_back(app_addr);
            if (app_cmd == 3'b000) begin
               n_wr++;
               waq.push_back(app_addr);
            end else begin
               n_rd++;
               rq.push_back(mem.exists(app_addr) ? mem[app_addr] : 64'd0);
               rq_ep.push_back(epoch);
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            n_beat++;
            wdq.push_back(app_wdf_data);
            beat_log.push_back(app_wdf_data);
         end
         while (waq.size() > 0 && wdq.size() > 0) mem[waq.pop_front()] = wdq.pop_front();
         p_en = app_en; p_rdy = app_rdy; p_addr = app_addr; p_cmd = app_cmd;
         p_wren = app_wdf_wren; p_wrdy = app_wdf_rdy; p_wdata = app_wdf_data; p_rst = rst;
         @(negedge clk);
         app_rdy     = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
         app_wdf_rdy = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
         if (!hold && rq.size() > 0 && (!bp || $urandom_range(0, 9) < 3)) begin
            d  = rq.pop_front();
            ep = rq_ep.pop_front();
            if (ep != epoch) d = ~d;
            if (n_rsp == flip_at) d[0] = ~d[0];
            n_rsp++;
            app_rd_data_valid = 1'b1;
            app_rd_data       = d;
         end else begin
            app_rd_data_valid = 1'b0;
         end
      end
   end

   int checks, failures;
   int s_wr, s_rd, s_beat, s_log, s_blog;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_test(input logic [1:0] m, input logic [26:0] b, input logic [31:0] s,
                           input int flip, input bit bpv);
      bp = bpv;
      @(negedge clk);
      s_wr = n_wr; s_rd = n_rd; s_beat = n_beat; s_log = addr_log.size(); s_blog = beat_log.size();
      flip_at = (flip < 0) ? -1 : n_rsp + flip;
      mode = m; base_addr = b; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
      bp = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [26:0] base;
      logic [31:0] seed;
      int          flip;
      bit          bp;
      bit          exp_pass;
      logic [15:0] exp_err;
      logic [26:0] exp_fea;
      int          exp_wr, exp_rd, exp_beats;
   } vec_t;
   vec_t vecs[7];

   initial begin
      rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; seed = '0; calib = 1'b1;
      bp = 0; hold = 0; flip_at = -1; epoch = 0; checks = 0; failures = 0;
      //          mode   base        seed          flip bp pass err     fea         wr  rd  beats
      vecs[0] = '{2'b00, 27'h000,    32'h00001000, -1, 0, 1, 16'd0,  27'h000,    16, 16, 16};
      vecs[1] = '{2'b00, 27'h100,    32'h00001000,  5, 0, 0, 16'd1,  27'h128,    16, 16, 16};
      vecs[2] = '{2'b00, 27'h040,    32'hDEADBEEF, -1, 1, 1, 16'd0,  27'h000,    16, 16, 16};
      vecs[3] = '{2'b01, 27'h200,    32'h00000007, -1, 0, 1, 16'd0,  27'h000,    16,  0, 16};
      vecs[4] = '{2'b10, 27'h200,    32'h00000007, -1, 0, 1, 16'd0,  27'h000,     0, 16,  0};
      vecs[5] = '{2'b10, 27'h200,    32'h00000008, -1, 0, 0, 16'd16, 27'h200,     0, 16,  0};
      vecs[6] = '{2'b00, 27'h300,    32'h00000055, 15, 1, 0, 16'd1,  27'h378,    16, 16, 16};

      repeat (3) @(negedge clk);
      chk("rst_ctl", {app_en, app_wdf_wren, app_wdf_end, busy, done, pass, timeout}, 0);
      chk("rst_cmd", app_cmd, 3'b001);
      chk("rst_addr", app_addr, 0);
      chk("rst_wdata", app_wdf_data, 0);
      chk("rst_mask", app_wdf_mask, 0);
      chk("rst_err", {err_count, first_err_addr}, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_test(vecs[i].mode, vecs[i].base, vecs[i].seed, vecs[i].flip, vecs[i].bp);
         chk($sformatf("v%0d_done", i), {done, busy, timeout}, 3'b100);
         chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
         chk($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
         chk($sformatf("v%0d_fea", i), first_err_addr, vecs[i].exp_fea);
         chk($sformatf("v%0d_wr", i), n_wr - s_wr, vecs[i].exp_wr);
         chk($sformatf("v%0d_rd", i), n_rd - s_rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_beats", i), n_beat - s_beat, vecs[i].exp_beats);
         chk($sformatf("v%0d_stable", i), stab_bad, 0);
      end

      // Clean pass detail: first beat and address sweep.
      run_test(2'b00, 27'h000, 32'h00001000, -1, 0);
      chk("clean_word0", beat_log[s_blog], 64'hFFFFEFFF_00001000);
      chk("clean_addr1", addr_log[s_log + 1], 27'd8);
      chk("clean_addr15", addr_log[s_log + 15], 27'd120);
      chk("clean_pass", pass, 1);

      // Address wrap past the top of the space; mode 11 behaves as 00.
      run_test(2'b11, 27'h7FFFFF0, 32'hFFFFFFFE, -1, 0);
      chk("wrap_a0", addr_log[s_log + 0], 27'h7FFFFF0);
      chk("wrap_a1", addr_log[s_log + 1], 27'h7FFFFF8);
      chk("wrap_a2", addr_log[s_log + 2], 27'h0);
      chk("wrap_a3", addr_log[s_log + 3], 27'h8);
      chk("wrap_rd", n_rd - s_rd, 16);
      chk("wrap_pass", {pass, err_count}, {1'b1, 16'd0});

      // Reset mid-READ, then a fresh read-only pass over data still in memory.
      hold = 1;
      @(negedge clk);
      mode = 2'b10; base_addr = 27'h100; seed = 32'h00001000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("rmr_busy", busy, 1);
      rst = 1'b1; epoch++;
      @(negedge clk);
      rst = 1'b0;
      chk("rmr_rst_ctl", {app_en, busy, done, pass, timeout}, 0);
      chk("rmr_rst_cmd", app_cmd, 3'b001);
      calib = 1'b0;
      s_rd = n_rd;
      mode = 2'b10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hold = 0;
      repeat (20) @(negedge clk);
      chk("rmr_stale_err", err_count, 0);
      chk("rmr_stale_busy", {busy, done}, 2'b10);
      calib = 1'b1;
      for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
      chk("rmr_done", done, 1);
      chk("rmr_pass", {pass, err_count}, {1'b1, 16'd0});
      chk("rmr_rd", n_rd - s_rd, 16);

      // Watchdog with calibration held low; a second start mid-way must be ignored.
      calib = 1'b0;
      @(negedge clk);
      mode = 2'b00; base_addr = 27'h0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("to_busy_rise", {busy, done}, 2'b10);
      repeat (28) @(negedge clk);
      base_addr = 27'h500; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (34) @(negedge clk);
      chk("to_early", {done, timeout}, 2'b00);
      @(negedge clk);
      chk("to_fire", {done, timeout, pass, busy}, 4'b1100);
      calib = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/ddr_pattern_tester.md
# ddr_pattern_tester

Parametrised traffic generator and checker for the MIG UI application port, replacing switch-driven single-command poking with a self-running memory test. On `start` it writes a deterministic pattern over `NUM_WORDS` consecutive UI words from `base_addr`, reads them back, compares each returned word, and reports pass/fail, error count and first failing address. It sits in the `ui_clk` domain between board-level control (switches/LEDs or a host) and `mig_nexys4ddr`.

## Interface
- `ADDR_WIDTH`, 27: MIG `app_addr` width.
- `APP_DATA_WIDTH`, 64: UI data width. Must be a multiple of 64.
- `APP_MASK_WIDTH`, 8: `APP_DATA_WIDTH/8`.
- `ADDR_STEP`, 8: `app_addr` increment per UI word.
- `NUM_WORDS`, 256: words per pass, 1..65535.
- `TIMEOUT`, 4096: max cycles without a handshake before abort.

Ports:
- `clk` in 1: MIG `ui_clk`. One clock; reset is synchronous and active-high.
- `rst` in 1: sync active-high; tie to `ui_clk_sync_rst` OR user reset.
- `start` in 1: one-cycle request, ignored while `busy`.
- `mode` in 2: 00 write+read, 01 write only, 10 read only, 11 treated as 00. Sampled with `start`.
- `base_addr` in ADDR_WIDTH: first address, sampled with `start`.
- `seed` in 32: pattern seed, sampled with `start`.
- `init_calib_complete` in 1: from MIG.
- `app_addr` out ADDR_WIDTH; `app_cmd` out 3; `app_en` out 1.
- `app_wdf_data` out APP_DATA_WIDTH; `app_wdf_mask` out APP_MASK_WIDTH (always 0); `app_wdf_wren` out 1; `app_wdf_end` out 1.
- `app_rdy`, `app_wdf_rdy`, `app_rd_data_valid` in 1; `app_rd_data` in APP_DATA_WIDTH.
- `busy` out 1; `done` out 1; `pass` out 1; `timeout` out 1.
- `err_count` out 16; `first_err_addr` out ADDR_WIDTH.

## Operation
- **Pattern.** Word i is built from `p = seed + i` (32-bit, wraps). Lane k (32 bits) = `p` for even k, `~p` for odd k.
- **Addressing.** Address of word i = `base_addr + i*ADDR_STEP`, modulo 2^ADDR_WIDTH, so wrap-around past the top address is legal.
- **IDLE.** On `start`, latch `mode`, `base_addr`, `seed`, clear all status, go to WAIT_CAL.
- **WAIT_CAL.** When `init_calib_complete`=1, go to WRITE, or to READ for mode 10.
- **WRITE.** Two independent counters run at once:
  - Command counter `cc`: `app_en`=1, `app_cmd`=000 while `cc`<NUM_WORDS; advances on `app_en&app_rdy`.
  - Data counter `dc`: `app_wdf_wren`=`app_wdf_end`=1 while `dc`<NUM_WORDS; advances on `app_wdf_wren&app_wdf_rdy`.
  - Data may lead command; `dc` never trails `cc` by more than 2.
  - When both counters reach NUM_WORDS, go to READ, or to DONE for mode 01.
- **READ.** `app_cmd`=001; `cc` restarts at 0 and issues reads as in WRITE.
  - Response counter `rc` advances on `app_rd_data_valid`; responses arrive in order.
  - Each response is compared to pattern(`rc`). On mismatch, `err_count` increments, saturating at 16'hFFFF. `first_err_addr` captures the address of the first mismatch only.
  - When `rc`=NUM_WORDS, go to DONE.
- **Watchdog.** Counts cycles in WAIT_CAL/WRITE/READ, cleared on any handshake or response. Reaching TIMEOUT sets `timeout`=1 and forces DONE with `pass`=0.
- **DONE.** `busy`=0, `done`=1. `pass` = (`err_count`==0 && !`timeout`). Holds until the next `start`, then behaves as IDLE.
- **Stray read data.** `app_rd_data_valid` outside READ is ignored.

## Timing
- Reset values: `app_en`, `app_wdf_wren`, `app_wdf_end`, `busy`, `done`, `pass`, `timeout` = 0. `err_count` = 0, `first_err_addr` = 0, `app_addr` = 0, `app_cmd` = 001, `app_wdf_data` = 0, `app_wdf_mask` = 0. State is IDLE.
- `rst` mid-test: outputs return to reset values the next cycle. Outstanding MIG reads are then discarded by the stray-read rule.
- `busy` rises the cycle after `start`. `start` while `busy` has no effect.
- Handshake stability:
  - Once `app_en` is high, `app_en`, `app_addr` and `app_cmd` hold until `app_rdy`=1 in the same cycle.
  - Likewise `app_wdf_wren` and `app_wdf_data` hold until `app_wdf_rdy`=1.
- Throughput: one command and one data beat per cycle when ready is held high. Minimum write phase is NUM_WORDS cycles.
- Compare is registered. `err_count` updates one cycle after the failing `app_rd_data_valid`. `done` rises the cycle after the final compare result is registered.

## Test plan
- **Clean pass.** MIG model with always-ready, mode 00, NUM_WORDS=16, seed=0x1000, base=0 → 16 writes to addrs 0,8,…,120. Word 0 = 64'hFFFFEFFF_00001000. Then `done`=1, `pass`=1, `err_count`=0.
- **Injected error.** Model flips bit 0 of read word 5, base=0x100 → `err_count`=1, `first_err_addr`=0x128, `pass`=0.
- **Backpressure.** Random `app_rdy`/`app_wdf_rdy` at 30% duty → addr/data stable during stalls. Exactly 16 commands and 16 beats are accepted, and the test passes.
- **Wrap-around.** base=2^27−16, NUM_WORDS=4 → addrs 0x7FFFFF0, 0x7FFFFF8, 0x0, 0x8.
- **Timeout.** `init_calib_complete` held low, TIMEOUT=64 → `timeout`=1 and `done`=1 at cycle 65 after `start`.
- **Reset mid-READ.** Reset during READ, then a new `start` in mode 10 → stale `app_rd_data_valid` pulses are ignored and counts are correct.
